osnt_bram_replay_reader: RTL and testbench

Downstream consumer of the OSNT packet-store BRAM. Reads stored AXI-Stream beats from a configured address window, unpacks each 736-bit word and replays it on a 512-bit AXI-Stream master, optionally looping N times. A small prefetch FIFO absorbs the BRAM's 1-cycle registered-read latency so backpressure never drops or duplicates a beat.

---
 rtl/osnt_bram_replay_reader_if.sv | 25 ++
 rtl/osnt_bram_replay_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_osnt_bram_replay_reader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osnt_bram_replay_reader_if.sv
// AXI-Stream bundle for the BRAM replay reader output.
// Master drives payload and valid, slave drives ready.
interface osnt_bram_replay_reader_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tlast;
  logic                     tready;

  modport master (
    output tdata, tkeep, tuser,
    output tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser,
    input  tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/osnt_bram_replay_reader.sv
// Replays stored AXI-S beats from a BRAM address window, optionally
// looping, through a prefetch FIFO that hides the 1-cycle read latency.
module osnt_bram_replay_reader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 736,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] addr_low,
  input  logic [ADDR_WIDTH-1:0] addr_high,
  input  logic [31:0]           replay_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [31:0]           pass_count,
  output logic [31:0]           pkt_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  bram_rst,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  osnt_bram_replay_reader_if.master m_axis
);

  localparam int KEEP_W   = TDATA_WIDTH / 8;
  localparam int USER_LSB = TDATA_WIDTH;
  localparam int KEEP_LSB = TDATA_WIDTH + TUSER_WIDTH;
  localparam int VLD_BIT  = KEEP_LSB + KEEP_W;
  localparam int LAST_BIT = VLD_BIT + 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                   last;
    logic [KEEP_W-1:0]      keep;
    logic [TUSER_WIDTH-1:0] user;
    logic [TDATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           pass_q, pass_d;
  logic [31:0]           pkt_q, pkt_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  inflight_q, inflight_d;
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  beat_t                 mem_q [FIFO_DEPTH];

  beat_t       in_beat;
  beat_t       head;
  logic        issue;
  logic        push;
  logic        pop;
  logic        tvalid;
  logic [CW:0] occ;
  logic        unused_rsvd;

  assign in_beat = {
    bram_rddata[LAST_BIT],
    bram_rddata[KEEP_LSB +: KEEP_W],
    bram_rddata[USER_LSB +: TUSER_WIDTH],
    bram_rddata[TDATA_WIDTH-1:0]
  };
  assign unused_rsvd = ^bram_rddata[DATA_WIDTH-1:LAST_BIT+1];

  // Reads in flight count against FIFO space so a stall never overflows.
  assign head   = mem_q[rp_q];
  assign tvalid = count_q != '0;
  assign occ    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue  = (state_q == RUN) && (occ < (CW+1)'(FIFO_DEPTH));
  assign push   = inflight_q && bram_rddata[VLD_BIT];
  assign pop    = tvalid && m_axis.tready;

  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? head.data : '0;
  assign m_axis.tkeep  = tvalid ? head.keep : '0;
  assign m_axis.tuser  = tvalid ? head.user : '0;
  assign m_axis.tlast  = tvalid ? head.last : 1'b0;

  assign bram_en     = issue;
  assign bram_addr   = rd_ptr_q;
  assign bram_we     = 1'b0;
  assign bram_rst    = 1'b0;
  assign bram_wrdata = '0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign pass_count = pass_q;
  assign pkt_count  = pkt_q;

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    pkt_d      = pkt_q;
    stop_d     = stop_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    inflight_d = issue;
    wp_d       = wp_q + PW'(push);
    rp_d       = rp_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (pop && head.last) begin
      pkt_d = pkt_q + 32'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (addr_low > addr_high) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d     = addr_low;
            hi_d     = addr_high;
            cnt_d    = replay_cnt;
            rd_ptr_d = addr_low;
            pass_d   = '0;
            pkt_d    = '0;
            stop_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (issue) begin
          if (rd_ptr_q == hi_q) begin
            pass_d = pass_q + 32'd1;
            if ((cnt_q != '0 && pass_q + 32'd1 == cnt_q)
                || stop_q || stop) begin
              state_d = DRAIN;
            end else begin
              rd_ptr_d = lo_q;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (count_d == '0 && !inflight_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pass_q     <= '0;
      pkt_q      <= '0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      inflight_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      pkt_q      <= pkt_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      inflight_q <= inflight_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is live.
  always_ff @(posedge axis_aclk) begin
    if (push) begin
      mem_q[wp_q] <= in_beat;
    end
  end

endmodule

// File: tb/tb_osnt_bram_replay_reader.sv
// Directed/random bench for osnt_bram_replay_reader with a BRAM model
// and a queue-based reference of the expected beat stream.
module tb_osnt_bram_replay_reader;
  localparam int AW = 16;
  localparam int DW = 736;
  localparam int TW = 512;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] addr_low = '0;
  logic [AW-1:0] addr_high = '0;
  logic [31:0]   replay_cnt = '0;
  logic          busy, done, cfg_err;
  logic [31:0]   pass_count, pkt_count;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_we, bram_rst;
  logic [DW-1:0] bram_wrdata;
  logic [DW-1:0] bram_rddata;

  osnt_bram_replay_reader_if #(
    .TDATA_WIDTH(TW),
    .TUSER_WIDTH(UW)
  ) m_axis ();

  osnt_bram_replay_reader dut (
    .axis_aclk   (clk),
    .axis_resetn (rstn),
    .start       (start),
    .stop        (stop),
    .addr_low    (addr_low),
    .addr_high   (addr_high),
    .replay_cnt  (replay_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .pass_count  (pass_count),
    .pkt_count   (pkt_count),
    .bram_addr   (bram_addr),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_rst    (bram_rst),
    .bram_wrdata (bram_wrdata),
    .bram_rddata (bram_rddata),
    .m_axis      (m_axis)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  always @(posedge clk) begin
    if (bram_en) bram_rddata <= mem[bram_addr[3:0]];
  end

  typedef logic [704:0] beat_t;

  beat_t      expq[$];
  beat_t      held;
  logic       hold = 1'b0;
  logic [TW-1:0] bad_data;
  logic       chk_bad = 1'b0;
  logic       start_req = 1'b0;
  logic       stop_req = 1'b0;
  int         mode = 0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         beats = 0;
  int         pkts = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  int         en_seen = 0;
  int         cfg_seen = 0;
  logic       done_seen = 1'b0;

  task automatic chk(input string tag, input logic [767:0] obs,
                     input logic [767:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int last_a, input int bad_a);
    logic [DW-1:0] w;
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 23; k++) w[k*32 +: 32] = $urandom;
      w[704] = (a != bad_a);
      w[705] = (a == last_a);
      mem[a] = w;
    end
  endtask

  // Expected stream: every valid word of the window, in address order, per pass
  task automatic build(input int lo, input int hi, input int passes);
    logic [DW-1:0] w;
    for (int p = 0; p < passes; p++) begin
      for (int a = lo; a <= hi; a++) begin
        w = mem[a];
        if (w[704]) expq.push_back({w[705], w[703:640], w[639:512], w[511:0]});
      end
    end
  endtask

  task automatic clr();
    expq.delete();
    beats = 0;
    pkts = 0;
    en_seen = 0;
    cfg_seen = 0;
    chk_bad = 1'b0;
    done_seen = 1'b0;
  endtask

  task automatic tick();
    beat_t cur;
    @(negedge clk);
    cyc++;
    start = start_req;
    stop = stop_req;
    start_req = 1'b0;
    stop_req = 1'b0;
    case (mode)
      0: m_axis.tready = 1'b1;
      1: m_axis.tready = !m_axis.tready;
      2: m_axis.tready = 1'($urandom_range(0, 1));
      default: m_axis.tready = 1'b0;
    endcase
    cur = {m_axis.tlast, m_axis.tkeep, m_axis.tuser, m_axis.tdata};
    if (hold && rstn) chk("hold_stable", {m_axis.tvalid, cur}, {1'b1, held});
    if (m_axis.tvalid && m_axis.tready) begin
      chk("beat_expected", expq.size() != 0, 1);
      if (expq.size() != 0) chk("beat", cur, expq.pop_front());
      if (chk_bad) chk("bad_word_seen", m_axis.tdata == bad_data, 0);
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
      if (m_axis.tlast) pkts++;
    end
    hold = m_axis.tvalid && !m_axis.tready;
    held = cur;
    if (done) done_seen = 1'b1;
    if (cfg_err) cfg_seen++;
    if (bram_en) en_seen++;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_seen, 1);
    chk("busy_at_done", busy, 0);
  endtask

  initial begin
    int n;
    m_axis.tready = 1'b0;
    mode = 3;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("tie_we_rst", {bram_we, bram_rst}, 0);
    chk("tie_wrdata", bram_wrdata, 0);
    rstn = 1'b1;
    tick();

    // Window 0..3, one pass, tready high: exact cycle timing
    clr();
    mode = 0;
    addr_low = 0;
    addr_high = 3;
    replay_cnt = 1;
    fill(3, -1);
    build(0, 3, 1);
    start_req = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t1_en_c%0d", c), bram_en, (c <= 4));
      if (c <= 4) chk($sformatf("t1_addr_c%0d", c), bram_addr, c - 1);
      chk($sformatf("t1_valid_c%0d", c), m_axis.tvalid, (c >= 3 && c <= 6));
      chk($sformatf("t1_done_c%0d", c), done, (c == 7));
      chk($sformatf("t1_busy_c%0d", c), busy, (c <= 6));
    end
    chk("t1_beats", beats, 4);
    chk("t1_pkts", pkts, 1);
    chk("t1_pass", pass_count, 1);
    chk("t1_pktcnt", pkt_count, 1);
    chk("t1_left", expq.size(), 0);

    // Three passes with tready toggling
    clr();
    mode = 1;
    replay_cnt = 3;
    fill(3, -1);
    build(0, 3, 3);
    start_req = 1'b1;
    run_until_done(300);
    chk("t2_beats", beats, 12);
    chk("t2_pkts", pkts, 3);
    chk("t2_pass", pass_count, 3);
    chk("t2_pktcnt", pkt_count, 3);
    chk("t2_left", expq.size(), 0);
    tick();
    chk("t2_done_pulse", done, 0);

    // Infinite replay, stop during pass 2
    clr();
    mode = 2;
    replay_cnt = 0;
    fill(3, -1);
    build(0, 3, 2);
    start_req = 1'b1;
    tick();
    n = 0;
    while (pass_count != 1 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_pass1_reached", pass_count, 1);
    stop_req = 1'b1;
    run_until_done(300);
    chk("t3_beats", beats, 8);
    chk("t3_pass", pass_count, 2);
    chk("t3_pktcnt", pkt_count, 2);
    chk("t3_left", expq.size(), 0);

    // Word 2 invalid: skipped every pass
    clr();
    mode = 2;
    replay_cnt = 2;
    fill(3, 2);
    bad_data = mem[2][511:0];
    chk_bad = 1'b1;
    build(0, 3, 2);
    start_req = 1'b1;
    run_until_done(300);
    chk("t4_beats", beats, 6);
    chk("t4_pass", pass_count, 2);
    chk("t4_pktcnt", pkt_count, 2);
    chk("t4_left", expq.size(), 0);

    // Bad window is rejected
    clr();
    mode = 0;
    addr_low = 5;
    addr_high = 4;
    replay_cnt = 1;
    start_req = 1'b1;
    tick();
    tick();
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_cfg_pulse", cfg_err, 0);
    repeat (3) tick();
    chk("t5_no_en", en_seen, 0);
    chk("t5_cfg_once", cfg_seen, 1);
    chk("t5_busy_end", busy, 0);

    // Single-word window: wraps every read, one beat per cycle
    clr();
    mode = 0;
    addr_low = 7;
    addr_high = 7;
    replay_cnt = 3;
    fill(7, -1);
    build(7, 7, 3);
    start_req = 1'b1;
    run_until_done(100);
    chk("t7_beats", beats, 3);
    chk("t7_pkts", pkts, 3);
    chk("t7_pass", pass_count, 3);
    chk("t7_back2back", last_cyc - first_cyc, 2);
    chk("t7_left", expq.size(), 0);

    // Reset during a stall, then a clean replay
    clr();
    mode = 3;
    addr_low = 0;
    addr_high = 3;
    replay_cnt = 0;
    fill(3, -1);
    start_req = 1'b1;
    repeat (8) tick();
    chk("t6_stalled_valid", m_axis.tvalid, 1);
    chk("t6_stalled_busy", busy, 1);
    rstn = 1'b0;
    tick();
    chk("t6_rst_valid", m_axis.tvalid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pass", pass_count, 0);
    chk("t6_rst_pkt", pkt_count, 0);
    chk("t6_rst_en", bram_en, 0);
    rstn = 1'b1;
    clr();
    mode = 2;
    addr_low = 1;
    addr_high = 3;
    replay_cnt = 1;
    build(1, 3, 1);
    start_req = 1'b1;
    tick();
    tick();
    chk("t6_restart_en", bram_en, 1);
    chk("t6_restart_addr", bram_addr, 1);
    run_until_done(200);
    chk("t6_beats", beats, 3);
    chk("t6_pkts", pkts, 1);
    chk("t6_pass", pass_count, 1);
    chk("t6_pktcnt", pkt_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
